// File: rtl/usb_tx_packet.sv
// USB transmit packetiser: builds handshake and DATA packets (PID, payload, CRC16)
// onto a byte-wide AXI-Stream towards the ULPI/PHY layer.
module usb_tx_packet #(
  parameter int unsigned MAX_PACKET = 512,
  parameter int unsigned CNT_W      = $clog2(MAX_PACKET + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hsk_send_i,
  input  logic [1:0]       hsk_type_i,
  output logic             hsk_sent_o,
  input  logic             data_start_i,
  input  logic [1:0]       data_pid_i,
  input  logic             data_zlp_i,
  input  logic             s_tvalid_i,
  output logic             s_tready_o,
  input  logic             s_tlast_i,
  input  logic [7:0]       s_tdata_i,
  output logic             m_tvalid_o,
  input  logic             m_tready_i,
  output logic             m_tlast_o,
  output logic [7:0]       m_tdata_o,
  output logic             busy_o,
  output logic             data_sent_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] byte_count_o
);

  typedef enum logic [2:0] {
    StIdle, StHsk, StPid, StData, StCrcLo, StCrcHi, StDrain
  } state_e;

  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [7:0]       out_data_q, out_data_d;
  logic [15:0]      crc_q, crc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zlp_q, zlp_d;
  logic             out_free;
  logic             out_acc;

  // Reflected CRC16 (poly 0x8005 -> 0xA001), one byte, LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 16'hA001;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Output register can take a new byte when empty or being consumed this cycle.
  assign out_free = !out_valid_q || m_tready_i;
  assign out_acc  = out_valid_q && m_tready_i;

  assign m_tvalid_o   = out_valid_q;
  assign m_tdata_o    = out_data_q;
  assign m_tlast_o    = out_last_q && out_valid_q;
  assign busy_o       = (state_q != StIdle);
  assign byte_count_o = cnt_q;

  // Next-state, output-register load and pulse generation.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_acc ? 1'b0 : out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    zlp_d       = zlp_q;
    s_tready_o  = 1'b0;
    hsk_sent_o  = 1'b0;
    data_sent_o = 1'b0;
    overflow_o  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Output register is always empty here: IDLE is entered only on the last byte's accept.
        if (hsk_send_i) begin
          out_valid_d = 1'b1;
          out_data_d  = {~{hsk_type_i, 2'b10}, hsk_type_i, 2'b10};
          out_last_d  = 1'b1;
          state_d     = StHsk;
        end else if (data_start_i) begin
          out_valid_d = 1'b1;
          out_data_d  = {~{data_pid_i, 2'b11}, data_pid_i, 2'b11};
          out_last_d  = 1'b0;
          zlp_d       = data_zlp_i;
          crc_d       = 16'hFFFF;
          cnt_d       = '0;
          state_d     = StPid;
        end
      end
      StHsk: begin
        if (out_acc) begin
          hsk_sent_o = 1'b1;
          state_d    = StIdle;
        end
      end
      StPid: begin
        if (out_acc) state_d = zlp_q ? StCrcLo : StData;
      end
      StData: begin
        s_tready_o = out_free;
        if (s_tvalid_i && out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = s_tdata_i;
          out_last_d  = 1'b0;
          crc_d       = crc16_byte(crc_q, s_tdata_i);
          cnt_d       = cnt_q + CNT_W'(1);
          if (s_tlast_i) begin
            state_d = StCrcLo;
          end else if (cnt_q == CNT_W'(MAX_PACKET - 1)) begin
            overflow_o = 1'b1;
            state_d    = StDrain;
          end
        end
      end
      StDrain: begin
        s_tready_o = 1'b1;
        if (s_tvalid_i && s_tlast_i) state_d = StCrcLo;
      end
      StCrcLo: begin
        if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = ~crc_q[7:0];
          out_last_d  = 1'b0;
          state_d     = StCrcHi;
        end
      end
      StCrcHi: begin
        // Register holds either the low CRC byte (last=0) or the high one (last=1).
        if (out_valid_q && out_last_q) begin
          if (m_tready_i) begin
            data_sent_o = 1'b1;
            state_d     = StIdle;
          end
        end else if (out_free) begin
          out_valid_d = 1'b1;
          out_data_d  = ~crc_q[15:8];
          out_last_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      crc_q       <= 16'hFFFF;
      cnt_q       <= '0;
      zlp_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      zlp_q       <= zlp_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_packet.sv
// Self-checking bench for usb_tx_packet: packet vector table plus reset sequences.
module tb_usb_tx_packet;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [1:0] hsk_send, data_start;
  logic [1:0] hsk_type, data_pid;
  logic       data_zlp;
  logic       s_tvalid, s_tlast, m_tready;
  logic [7:0] s_tdata;

  logic [1:0] m_tvalid_w, m_tlast_w, s_tready_w, busy_w, hsk_sent_w, data_sent_w, ovf_w;
  logic [7:0] m_tdata_w [2];
  logic [9:0] cnt_a;
  logic [3:0] cnt_b;

  // sel=0: default instance (MAX_PACKET=512), sel=1: MAX_PACKET=8 instance.
  logic        sel;
  logic        mv, mlast, sready, busy_s, hsent_s, dsent_s, ovf_s;
  logic [7:0]  mdata;
  logic [10:0] cnt_s;

  assign mv      = m_tvalid_w[sel];
  assign mlast   = m_tlast_w[sel];
  assign mdata   = m_tdata_w[sel];
  assign sready  = s_tready_w[sel];
  assign busy_s  = busy_w[sel];
  assign hsent_s = hsk_sent_w[sel];
  assign dsent_s = data_sent_w[sel];
  assign ovf_s   = ovf_w[sel];
  assign cnt_s   = sel ? 11'(cnt_b) : 11'(cnt_a);

  usb_tx_packet u_dut (
    .clk(clk), .rst(rst),
    .hsk_send_i(hsk_send[0]), .hsk_type_i(hsk_type), .hsk_sent_o(hsk_sent_w[0]),
    .data_start_i(data_start[0]), .data_pid_i(data_pid), .data_zlp_i(data_zlp),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready_w[0]), .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
    .m_tvalid_o(m_tvalid_w[0]), .m_tready_i(m_tready), .m_tlast_o(m_tlast_w[0]),
    .m_tdata_o(m_tdata_w[0]), .busy_o(busy_w[0]), .data_sent_o(data_sent_w[0]),
    .overflow_o(ovf_w[0]), .byte_count_o(cnt_a)
  );

  usb_tx_packet #(.MAX_PACKET(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .hsk_send_i(hsk_send[1]), .hsk_type_i(hsk_type), .hsk_sent_o(hsk_sent_w[1]),
    .data_start_i(data_start[1]), .data_pid_i(data_pid), .data_zlp_i(data_zlp),
    .s_tvalid_i(s_tvalid), .s_tready_o(s_tready_w[1]), .s_tlast_i(s_tlast), .s_tdata_i(s_tdata),
    .m_tvalid_o(m_tvalid_w[1]), .m_tready_i(m_tready), .m_tlast_o(m_tlast_w[1]),
    .m_tdata_o(m_tdata_w[1]), .busy_o(busy_w[1]), .data_sent_o(data_sent_w[1]),
    .overflow_o(ovf_w[1]), .byte_count_o(cnt_b)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  typedef struct packed {
    logic         sel;
    logic         hsk;
    logic         both;
    logic [1:0]   typ;
    logic         zlp;
    logic         stall;
    logic [4:0]   plen;
    logic [127:0] pay;
    logic [4:0]   elen;
    logic [127:0] exp;
    logic [10:0]  ecnt;
    logic         eovf;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [127:0] seq_bytes(input logic [7:0] first, input int n);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < n; i++) p[i*8 +: 8] = first + 8'(i);
    return p;
  endfunction

  // Non-reflected CRC16 (0x8005) on bit-reversed data, result reversed and inverted.
  function automatic logic [15:0] crc_model(input logic [127:0] pay, input int n);
    logic [15:0] c;
    logic [15:0] r;
    logic        fb;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[15] ^ pay[i*8 + b];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h8005;
      end
    end
    for (int b = 0; b < 16; b++) r[b] = c[15-b];
    return ~r;
  endfunction

  function automatic logic [127:0] build_exp(input logic [7:0] pid, input logic [127:0] pay,
                                             input int n);
    logic [127:0] e;
    logic [15:0]  c;
    e = '0;
    e[7:0] = pid;
    for (int i = 0; i < n; i++) e[(i+1)*8 +: 8] = pay[i*8 +: 8];
    c = crc_model(pay, n);
    e[(n+1)*8 +: 8] = c[7:0];
    e[(n+2)*8 +: 8] = c[15:8];
    return e;
  endfunction

  function automatic vec_t mk(input logic s, input logic h, input logic b, input logic [1:0] t,
                              input logic z, input logic st, input int pl, input logic [127:0] p,
                              input int el, input logic [127:0] e, input int ec, input logic ov);
    vec_t v;
    v.sel = s; v.hsk = h; v.both = b; v.typ = t; v.zlp = z; v.stall = st;
    v.plen = 5'(pl); v.pay = p; v.elen = 5'(el); v.exp = e; v.ecnt = 11'(ec); v.eovf = ov;
    return v;
  endfunction

  task automatic run_vec(input int k);
    vec_t       v;
    int         pi, ng, n_hsk, n_dsent, n_ovf, first_cyc, plen_i;
    logic       done, s_acc_prev, hold_v, hold_l;
    logic [7:0] hold_d;
    logic [7:0] got [16];
    v = vecs[k];
    sel = v.sel;
    plen_i = int'(v.plen);
    pi = 0; ng = 0; n_hsk = 0; n_dsent = 0; n_ovf = 0; first_cyc = -1;
    done = 1'b0; s_acc_prev = 1'b0; hold_v = 1'b0; hold_l = 1'b0; hold_d = 8'h00;
    s_tvalid = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      // Type fields change after the start cycle to show they are latched.
      hsk_type = (cyc == 0) ? v.typ : ~v.typ;
      data_pid = (cyc == 0) ? v.typ : ~v.typ;
      data_zlp = (cyc == 0) ? v.zlp : ~v.zlp;
      hsk_send   = '0;
      data_start = '0;
      if (cyc == 0) begin
        hsk_send[v.sel]   = v.hsk;
        data_start[v.sel] = !v.hsk || v.both;
      end
      m_tready = v.stall ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!s_tvalid || s_acc_prev)
        s_tvalid = (pi < plen_i) && (!v.stall || $urandom_range(0, 1) == 1);
      s_tdata = v.pay[pi*8 +: 8];
      s_tlast = (pi == plen_i - 1);
      #1;
      if (hold_v) begin
        check("stall_valid", mv, 1'b1);
        check("stall_data", mdata, hold_d);
        check("stall_last", mlast, hold_l);
      end
      s_acc_prev = s_tvalid && sready;
      if (s_acc_prev) pi++;
      if (mv && first_cyc < 0) first_cyc = cyc;
      if (hsent_s) n_hsk++;
      if (dsent_s) n_dsent++;
      if (ovf_s) n_ovf++;
      if (mv && m_tready) begin
        if (ng < 16) got[ng] = mdata;
        ng++;
        if (mlast) done = 1'b1;
        hold_v = 1'b0;
      end else if (mv) begin
        hold_v = 1'b1; hold_d = mdata; hold_l = mlast;
      end else begin
        hold_v = 1'b0;
      end
    end
    hsk_send = '0; data_start = '0; s_tvalid = 1'b0; m_tready = 1'b1;
    check("pkt_done", done, 1'b1);
    check("pkt_len", ng, int'(v.elen));
    for (int i = 0; i < int'(v.elen) && i < 16; i++)
      check($sformatf("v%0d_byte%0d", k, i), (i < ng) ? got[i] : 8'hxx, v.exp[i*8 +: 8]);
    if (!v.stall) check("pid_latency", first_cyc, 1);
    check("hsk_sent_pulses", n_hsk, 32'(v.hsk));
    check("data_sent_pulses", n_dsent, 32'(!v.hsk));
    check("overflow_pulses", n_ovf, 32'(v.eovf));
    check("payload_consumed", pi, plen_i);
    if (!v.hsk) check("byte_count", cnt_s, v.ecnt);
    @(negedge clk);
    #1;
    check("idle_busy", busy_s, 1'b0);
    check("idle_valid", mv, 1'b0);
  endtask

  initial begin
    int   pi_r;
    int   extra;
    logic found;

    vecs[0]  = mk(0, 1, 0, 2'b00, 0, 0, 0, '0, 1, 128'(8'hD2), 0, 0);
    vecs[1]  = mk(0, 1, 0, 2'b10, 0, 0, 0, '0, 1, 128'(8'h5A), 0, 0);
    vecs[2]  = mk(0, 1, 0, 2'b11, 0, 0, 0, '0, 1, 128'(8'h1E), 0, 0);
    vecs[3]  = mk(0, 1, 0, 2'b01, 0, 0, 0, '0, 1, 128'(8'h96), 0, 0);
    vecs[4]  = mk(0, 0, 0, 2'b10, 1, 0, 0, '0, 3, 128'({8'h00, 8'h00, 8'h4B}), 0, 0);
    vecs[5]  = mk(0, 0, 0, 2'b00, 0, 0, 9, seq_bytes(8'h31, 9), 12,
                  128'({8'hB4, 8'hC8, 8'h39, 8'h38, 8'h37, 8'h36, 8'h35, 8'h34, 8'h33,
                        8'h32, 8'h31, 8'hC3}), 9, 0);
    vecs[6]  = vecs[5];
    vecs[6].stall = 1'b1;
    vecs[7]  = mk(1, 0, 0, 2'b00, 0, 0, 12, seq_bytes(8'h41, 12), 11,
                  build_exp(8'hC3, seq_bytes(8'h41, 12), 8), 8, 1);
    vecs[8]  = mk(1, 0, 0, 2'b10, 0, 0, 4, seq_bytes(8'h61, 4), 7,
                  build_exp(8'h4B, seq_bytes(8'h61, 4), 4), 4, 0);
    vecs[9]  = mk(1, 0, 0, 2'b01, 0, 0, 8, seq_bytes(8'h10, 8), 11,
                  build_exp(8'h87, seq_bytes(8'h10, 8), 8), 8, 0);
    vecs[10] = mk(0, 1, 1, 2'b00, 0, 0, 0, '0, 1, 128'(8'hD2), 0, 0);

    sel = 1'b0; rst = 1'b1;
    hsk_send = '0; data_start = '0; hsk_type = '0; data_pid = '0; data_zlp = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_m_tvalid", m_tvalid_w[i], 1'b0);
      check("rst_m_tlast", m_tlast_w[i], 1'b0);
      check("rst_s_tready", s_tready_w[i], 1'b0);
      check("rst_busy", busy_w[i], 1'b0);
      check("rst_hsk_sent", hsk_sent_w[i], 1'b0);
      check("rst_data_sent", data_sent_w[i], 1'b0);
      check("rst_overflow", ovf_w[i], 1'b0);
    end
    check("rst_count_a", cnt_a, 0);
    check("rst_count_b", cnt_b, 0);
    rst = 1'b0;

    for (int k = 0; k < 11; k++) run_vec(k);

    // Reset while the third payload byte is on the output.
    sel = 1'b0; pi_r = 0; found = 1'b0;
    @(negedge clk);
    data_start = 2'b01; data_pid = 2'b00; data_zlp = 1'b0; m_tready = 1'b1;
    for (int c = 0; c < 50 && !found; c++) begin
      @(negedge clk);
      data_start = '0;
      s_tvalid = 1'b1; s_tdata = 8'h31 + 8'(pi_r); s_tlast = 1'b0;
      #1;
      if (s_tready_w[0]) pi_r++;
      if (m_tvalid_w[0] && m_tdata_w[0] == 8'h33) begin
        found = 1'b1;
        rst = 1'b1;
        s_tvalid = 1'b0;
      end
    end
    check("midrst_byte3_seen", found, 1'b1);
    @(negedge clk);
    #1;
    check("midrst_valid", m_tvalid_w[0], 1'b0);
    check("midrst_last", m_tlast_w[0], 1'b0);
    check("midrst_busy", busy_w[0], 1'b0);
    check("midrst_count", cnt_a, 0);
    rst = 1'b0;
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (m_tvalid_w[0] || busy_w[0]) extra++;
    end
    check("midrst_no_resume", extra, 0);

    run_vec(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_tx_packet.md
USB_TX_PACKET -- requirements
Module: usb_tx_packet

Interface
REQ-001 SHALL have parameter MAX_PACKET, default 512, meaning the maximum payload bytes per DATA packet (legal range 8..1024).
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_PACKET+1), meaning the width of the byte counter.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port hsk_send_i, input, 1 bit: request to send a handshake packet.
REQ-006 SHALL have port hsk_type_i, input, 2 bits: handshake type, 00 ACK, 10 NAK, 11 STALL, 01 NYET.
REQ-007 SHALL have port hsk_sent_o, output, 1 bit: one-cycle pulse when the handshake byte is accepted downstream.
REQ-008 SHALL have port data_start_i, input, 1 bit: request to send a DATA packet.
REQ-009 SHALL have port data_pid_i, input, 2 bits: data PID[3:2], 00 DATA0, 10 DATA1, 01 DATA2, 11 MDATA.
REQ-010 SHALL have port data_zlp_i, input, 1 bit: the requested DATA packet is zero-length; sampled with data_start_i.
REQ-011 SHALL have ports s_tvalid_i (in, 1), s_tready_o (out, 1), s_tlast_i (in, 1) and s_tdata_i (in, 8): the AXI-S payload input.
REQ-012 SHALL have ports m_tvalid_o (out, 1), m_tready_i (in, 1), m_tlast_o (out, 1) and m_tdata_o (out, 8): the AXI-S packet output to the ULPI/PHY layer.
REQ-013 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not IDLE.
REQ-014 SHALL have port data_sent_o, output, 1 bit: one-cycle pulse when the CRC high byte is accepted downstream.
REQ-015 SHALL have port overflow_o, output, 1 bit: one-cycle pulse when a payload is truncated at MAX_PACKET.
REQ-016 SHALL have port byte_count_o, output, CNT_W bits: number of payload bytes accepted in the current or last packet.

Function
REQ-017 SHALL implement FSM states IDLE, HSK, PID, DATA, CRC_LO, CRC_HI and DRAIN.
REQ-018 SHALL, in IDLE, move to HSK on hsk_send_i, else to PID on data_start_i; handshake has priority when both are high.
REQ-019 SHALL ignore hsk_send_i and data_start_i in every state other than IDLE.
REQ-020 SHALL form each PID byte as {~pid, pid}: handshake pid = {hsk_type_i, 2'b10}, data pid = {data_pid_i, 2'b11}; type fields latched at acceptance.
REQ-021 SHALL drive m_tvalid_o with the PID byte on the cycle after the start is accepted (one-cycle latency).
REQ-022 SHALL use a registered output stage: m_tdata_o/m_tlast_o stable while m_tvalid_o=1 and m_tready_i=0; the register reloads only when empty or consumed.
REQ-023 SHALL, in HSK, emit the single PID byte with m_tlast_o=1, pulse hsk_sent_o on acceptance, then return to IDLE.
REQ-024 SHALL go PID->CRC_LO when zlp is latched, else PID->DATA, on PID-byte acceptance.
REQ-025 SHALL assert s_tready_o = (state==DATA) && (output register empty or consumed this cycle); in DRAIN, s_tready_o=1.
REQ-026 SHALL, in DATA, hold and wait with no output byte when s_tvalid_i=0 (no underrun termination, no bubbles emitted with m_tvalid_o=1).
REQ-027 SHALL, per accepted payload byte, forward it, update CRC16 and increment byte_count_o (cleared at packet start).
REQ-028 SHALL leave DATA for CRC_LO when the accepted byte has s_tlast_i=1.
REQ-029 SHALL, when the MAX_PACKET-th byte is accepted with s_tlast_i=0, pulse overflow_o, go to DRAIN, discard input through s_tlast_i, then emit CRC_LO.
REQ-030 SHALL compute CRC16 with init 16'hFFFF, reflected polynomial 0x8005, LSB-first, and transmit the complement low byte then high byte (CRC_HI with m_tlast_o=1).
REQ-031 SHALL, on CRC_HI acceptance, pulse data_sent_o and return to IDLE.

Reset
REQ-032 SHALL, on rst, set the state to IDLE, drive m_tvalid_o, m_tlast_o, s_tready_o, busy_o, hsk_sent_o, data_sent_o and overflow_o to 0, byte_count_o to 0, and the CRC to 16'hFFFF.
REQ-033 SHALL, on rst mid-packet, drop m_tvalid_o on the next cycle without emitting m_tlast_o; the aborted packet is not resumed.

Verification
REQ-034 SHALL be verified by: hsk_send_i, type 00, m_tready_i=1 -> one byte 0xD2, tlast=1, hsk_sent_o pulse; types 10/11/01 -> 0x5A/0x1E/0x96.
REQ-035 SHALL be verified by: data_start_i, pid 10, zlp=1 -> bytes 0x4B, 0x00, 0x00, tlast on the last byte, data_sent_o pulse, byte_count_o=0.
REQ-036 SHALL be verified by: DATA0 with payload ASCII "123456789" -> bytes 0xC3, 0x31..0x39, 0xC8, 0xB4; byte_count_o=9.
REQ-037 SHALL be verified by: random m_tready_i and s_tvalid_i stalls on the same payload -> identical byte stream, no byte lost or duplicated, data stable while stalled.
REQ-038 SHALL be verified by: MAX_PACKET=8 with a 12-byte input -> 8 payload bytes plus valid CRC, overflow_o pulse, 4 bytes drained, next packet correct.
REQ-039 SHALL be verified by: hsk_send_i and data_start_i together -> handshake only; rst asserted at payload byte 3 -> m_tvalid_o=0 next cycle, busy_o=0.
